// File: rtl/cpu_status_pkg.sv
// Shared constants and types for the CPU status UART return path.
package cpu_status_pkg;

  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_BYTES_BASE    = 8;

  localparam logic [3:0] IDX_HDR   = 4'd0;
  localparam logic [3:0] IDX_PC    = 4'd1;
  localparam logic [3:0] IDX_OP    = 4'd2;
  localparam logic [3:0] IDX_ACC_H = 4'd3;
  localparam logic [3:0] IDX_ACC_L = 4'd4;
  localparam logic [3:0] IDX_MR_H  = 4'd5;
  localparam logic [3:0] IDX_MR_L  = 4'd6;
  localparam logic [3:0] IDX_FLAGS = 4'd7;
  localparam logic [3:0] IDX_CSUM  = 4'd8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [7:0] status_byte(input logic halt, input logic [4:0] flags);
    return {2'b00, halt, flags};
  endfunction

endpackage

// File: rtl/cpu_status_uart_tx_byte.sv
// Single-byte 8N1 transmitter with valid/ready handshake; can chain bytes with no idle gap.
module uart_tx_byte import cpu_status_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          bit_last;

  assign bit_last    = (cnt_q == CW'(CLKS_PER_BIT - 1));
  // Stop bit finishing this cycle: a new byte may be taken right here.
  assign o_byte_done = (state_q == TX_STOP) && bit_last;
  assign o_ready     = (state_q == TX_IDLE) || o_byte_done;
  assign o_tx        = tx_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
    end else begin
      cnt_q <= bit_last ? '0 : cnt_q + CW'(1);
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          if (i_valid) begin
            state_q <= TX_START;
            sh_q    <= i_data;
            tx_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_last) begin
            state_q   <= TX_DATA;
            bit_idx_q <= '0;
            tx_q      <= sh_q[0];
          end
        end
        TX_DATA: begin
          if (bit_last) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              sh_q      <= {1'b0, sh_q[7:1]};
              tx_q      <= sh_q[1];
            end
          end
        end
        TX_STOP: begin
          if (bit_last) begin
            if (i_valid) begin
              state_q <= TX_START;
              sh_q    <= i_data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_status_uart_tx.sv
// Snapshots CPU status on request and streams it as a fixed UART byte frame.
// Optional checksum byte enabled by STATUS_TX_CHECKSUM_EN.
module cpu_status_uart_tx import cpu_status_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  input  logic [7:0]  i_pc,
  input  logic [7:0]  i_opcode,
  input  logic [15:0] i_acc,
  input  logic [15:0] i_mr,
  input  logic [4:0]  i_flags,
  input  logic        i_halt,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

`ifdef STATUS_TX_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = FRAME_BYTES_BASE + 1;
`else
  localparam int unsigned FRAME_BYTES = FRAME_BYTES_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  typedef enum logic {StIdle, StSend} frame_state_e;

  frame_state_e state_q;
  logic [3:0]   idx_q;
  logic         busy_q, done_q, overrun_q;
  logic [7:0]   pc_q, op_q, st_q;
  logic [15:0]  acc_q, mr_q;
`ifdef STATUS_TX_CHECKSUM_EN
  logic [7:0]   csum_q;
`endif

  logic       byte_ready, byte_done, tx_valid;
  logic [7:0] tx_data, mux_byte;
  logic [3:0] next_idx;

  always_comb begin
    next_idx = idx_q + 4'd1;
    case (next_idx)
      IDX_PC:    mux_byte = pc_q;
      IDX_OP:    mux_byte = op_q;
      IDX_ACC_H: mux_byte = acc_q[15:8];
      IDX_ACC_L: mux_byte = acc_q[7:0];
      IDX_MR_H:  mux_byte = mr_q[15:8];
      IDX_MR_L:  mux_byte = mr_q[7:0];
      IDX_FLAGS: mux_byte = st_q;
`ifdef STATUS_TX_CHECKSUM_EN
      IDX_CSUM:  mux_byte = csum_q;
`endif
      default:   mux_byte = HEADER_BYTE;
    endcase
    // Header goes out straight from the request so the start bit appears next cycle.
    tx_data  = (state_q == StIdle) ? HEADER_BYTE : mux_byte;
    tx_valid = byte_ready & (((state_q == StIdle) & i_send) |
                             ((state_q == StSend) & byte_done & (idx_q != LAST_IDX)));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      pc_q      <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      mr_q      <= '0;
      st_q      <= '0;
`ifdef STATUS_TX_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      overrun_q <= i_send & busy_q;
      case (state_q)
        StIdle: begin
          if (i_send) begin
            state_q <= StSend;
            idx_q   <= IDX_HDR;
            busy_q  <= 1'b1;
            pc_q    <= i_pc;
            op_q    <= i_opcode;
            acc_q   <= i_acc;
            mr_q    <= i_mr;
            st_q    <= status_byte(i_halt, i_flags);
`ifdef STATUS_TX_CHECKSUM_EN
            csum_q  <= i_pc ^ i_opcode ^ i_acc[15:8] ^ i_acc[7:0] ^ i_mr[15:8] ^ i_mr[7:0] ^
                       status_byte(i_halt, i_flags);
`endif
          end
        end
        StSend: begin
          if (byte_done) begin
            if (idx_q == LAST_IDX) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= next_idx;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (tx_valid),
    .i_data     (tx_data),
    .o_ready    (byte_ready),
    .o_byte_done(byte_done),
    .o_tx       (o_tx)
  );

  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_overrun    = overrun_q;

endmodule
